// File: rtl/mandel_coord_gen.sv
// rtl/mandel_coord_gen.sv - raster-order complex-plane coordinate generator for a mandelbrot pipeline
// Walks a H_RES x V_RES frame in Q8.24, emitting one (c_real, c_imag, px_x, px_y) sample per handshake.
module mandel_coord_gen #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int XW    = 10,
    parameter int YW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [31:0]   origin_real,
    input  logic [31:0]   origin_imag,
    input  logic [31:0]   step,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [31:0]   c_real,
    output logic [31:0]   c_imag,
    output logic [XW-1:0] px_x,
    output logic [YW-1:0] px_y,
    output logic          busy,
    output logic          frame_done
);

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [31:0]   orig_re_q;
    logic [31:0]   row_im_q;
    logic [31:0]   step_q;
    logic [31:0]   c_real_q;
    logic [31:0]   c_imag_q;
    logic [XW-1:0] px_x_q;
    logic [YW-1:0] px_y_q;
    logic          out_valid_q;
    logic          busy_q;
    logic          frame_done_q;

    logic          xfer;
    logic          x_last;
    logic          y_last;
    logic [31:0]   c_real_d;
    logic [31:0]   row_im_d;

    assign xfer     = out_valid_q & out_ready;
    assign x_last   = (px_x_q == X_LAST);
    assign y_last   = (px_y_q == Y_LAST);
    // Arithmetic wraps modulo 2^32 by construction; no saturation on purpose.
    assign c_real_d = c_real_q + step_q;
    assign row_im_d = row_im_q - step_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            orig_re_q    <= '0;
            row_im_q     <= '0;
            step_q       <= '0;
            c_real_q     <= '0;
            c_imag_q     <= '0;
            px_x_q       <= '0;
            px_y_q       <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    frame_done_q <= 1'b0;
                    if (start) begin
                        orig_re_q   <= origin_real;
                        row_im_q    <= origin_imag;
                        step_q      <= step;
                        c_real_q    <= origin_real;
                        c_imag_q    <= origin_imag;
                        px_x_q      <= '0;
                        px_y_q      <= '0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        if (!x_last) begin
                            px_x_q   <= px_x_q + XW'(1);
                            c_real_q <= c_real_d;
                        end else if (!y_last) begin
                            // Row wrap: real part restarts, imaginary part steps downward.
                            px_x_q   <= '0;
                            c_real_q <= orig_re_q;
                            px_y_q   <= px_y_q + YW'(1);
                            row_im_q <= row_im_d;
                            c_imag_q <= row_im_d;
                        end else begin
                            out_valid_q  <= 1'b0;
                            frame_done_q <= 1'b1;
                            state_q      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    out_valid_q  <= 1'b0;
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign c_real     = c_real_q;
    assign c_imag     = c_imag_q;
    assign px_x       = px_x_q;
    assign px_y       = px_y_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mandel_coord_gen.sv
// tb/tb_mandel_coord_gen.sv - self-checking bench for mandel_coord_gen with a raster reference model
module tb_mandel_coord_gen;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int N  = H * V;
    localparam int XW = 10;
    localparam int YW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   origin_real;
    logic [31:0]   origin_imag;
    logic [31:0]   step;
    logic          out_ready;
    logic          out_valid;
    logic [31:0]   c_real;
    logic [31:0]   c_imag;
    logic [XW-1:0] px_x;
    logic [YW-1:0] px_y;
    logic          busy;
    logic          frame_done;

    int tests = 0;
    int fails = 0;

    logic [31:0] cap_re [N];
    logic [31:0] cap_im [N];
    int          cap_x  [N];
    int          cap_y  [N];

    always #5 clk = ~clk;

    mandel_coord_gen #(
        .H_RES(H),
        .V_RES(V),
        .XW   (XW),
        .YW   (YW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .origin_real(origin_real),
        .origin_imag(origin_imag),
        .step       (step),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .c_real     (c_real),
        .c_imag     (c_imag),
        .px_x       (px_x),
        .px_y       (px_y),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 ready high, 1 five-cycle stall at (2,1), 2 random ready,
    //       3 start pulse + origin change mid-frame, 4 reset while transfer 7 is presented
    task automatic run_frame(input logic [31:0] ore, input logic [31:0] oim, input logic [31:0] stp,
                             input int mode, output int done_cyc);
        int          n;
        int          stalls;
        int          stall6;
        int          dones;
        bit          pulsed;
        logic        rdy;
        logic [31:0] exp_re;
        logic [31:0] exp_im;
        n        = 0;
        stalls   = 0;
        stall6   = 0;
        pulsed   = 0;
        done_cyc = -1;
        @(negedge clk);
        origin_real = ore;
        origin_imag = oim;
        step        = stp;
        out_ready   = 1'b1;
        start       = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (frame_done) begin
                done_cyc = cyc;
                check("done_transfers", 64'(n), 64'(N));
                check("done_valid", 64'(out_valid), 64'd0);
                check("done_busy", 64'(busy), 64'd1);
                check("done_latency", 64'(cyc), 64'(N + 1 + stalls));
                break;
            end
            exp_re = ore + 32'(n % H) * stp;
            exp_im = oim - 32'((n / H) % V) * stp;
            check("run_busy", 64'(busy), 64'd1);
            check("run_valid", 64'(out_valid), 64'd1);
            check("c_real", 64'(c_real), 64'(exp_re));
            check("c_imag", 64'(c_imag), 64'(exp_im));
            check("px_x", 64'(px_x), 64'(n % H));
            check("px_y", 64'(px_y), 64'((n / H) % V));
            if (mode == 3 && n == 5 && !pulsed) begin
                start       = 1'b1;
                origin_real = 32'h0;
                pulsed      = 1;
            end
            if (mode == 4 && n == 6) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("rst_valid", 64'(out_valid), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_coords", {c_real, c_imag}, 64'd0);
                check("rst_px", 64'({px_x, px_y}), 64'd0);
                dones = 0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (frame_done || out_valid) dones++;
                end
                check("rst_quiet", 64'(dones), 64'd0);
                done_cyc = 0;
                return;
            end
            case (mode)
                1: rdy = !(n == 6 && stall6 < 5);
                2: rdy = 1'($urandom_range(0, 1));
                default: rdy = 1'b1;
            endcase
            if (!rdy) begin
                stalls++;
                if (n == 6) stall6++;
            end
            out_ready = rdy;
            if (rdy) begin
                cap_re[n % N] = c_real;
                cap_im[n % N] = c_imag;
                cap_x[n % N]  = int'(px_x);
                cap_y[n % N]  = int'(px_y);
                n++;
            end
        end
        check("frame_done_seen", 64'(done_cyc > 0), 64'd1);
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(frame_done), 64'd0);
        out_ready = 1'b1;
    endtask

    initial begin
        int d;
        reset       = 1'b1;
        start       = 1'b1;
        origin_real = 32'h1234_5678;
        origin_imag = 32'h0BAD_F00D;
        step        = 32'h0000_1000;
        out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_flags", 64'({out_valid, busy, frame_done}), 64'd0);
        check("reset_coords", {c_real, c_imag}, 64'd0);
        check("reset_px", 64'({px_x, px_y}), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_idle", 64'({out_valid, busy}), 64'd0);

        run_frame(32'hFE00_0000, 32'h0100_0000, 32'h0010_0000, 0, d);
        check("d_frame_latency", 64'(d), 64'd13);
        check("t4_c_real", 64'(cap_re[3]), 64'hFE30_0000);
        check("t4_xy", 64'({cap_x[3][15:0], cap_y[3][15:0]}), 64'h0003_0000);
        check("t5_c_real", 64'(cap_re[4]), 64'hFE00_0000);
        check("t5_c_imag", 64'(cap_im[4]), 64'h00F0_0000);
        check("t5_xy", 64'({cap_x[4][15:0], cap_y[4][15:0]}), 64'h0000_0001);
        check("t12_c_imag", 64'(cap_im[11]), 64'h00E0_0000);
        check("t12_xy", 64'({cap_x[11][15:0], cap_y[11][15:0]}), 64'h0003_0002);

        run_frame(32'hFE00_0000, 32'h0100_0000, 32'h0010_0000, 1, d);
        check("stall_latency", 64'(d), 64'd18);

        run_frame(32'hFE00_0000, 32'h0100_0000, 32'h0010_0000, 3, d);
        check("midframe_start_t12", 64'(cap_re[11]), 64'hFE30_0000);
        origin_real = 32'hFE00_0000;

        run_frame(32'hFF00_0000, 32'h0080_0000, 32'h0004_0000, 4, d);
        run_frame(32'hFF00_0000, 32'h0080_0000, 32'h0004_0000, 0, d);
        check("after_reset_frame", 64'(d), 64'd13);

        run_frame(32'h7FF0_0000, 32'h0000_0000, 32'h0010_0000, 0, d);
        check("wrap_t2", 64'(cap_re[1]), 64'h8000_0000);

        for (int r = 0; r < 3; r++) begin
            run_frame($urandom, $urandom, $urandom, 2, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
